// File: rtl/iir_biquad_seq.sv
// iir_biquad_seq
// ---------------
// Purpose:
//   Time-multiplexed direct-form-I second-order IIR section. It reads the taps
//   of an external three-tap sample delay line. It runs five multiply-accumulate
//   steps on a single multiplier, and keeps its own output history (y1, y2).
//   It then issues the shift pulse that advances the delay line.
//
//       y[k] = (b0*x[k] + b1*x[k-1] + b2*x[k-2] - a1*y1 - a2*y2) >>> FRAC
//
//   State sequence: IDLE -> M0 -> M1 -> M2 -> M3 -> M4 -> OUT -> IDLE
//
// Configuration:
//   IIR_SAT_EN  When defined, the result is clamped to the signed N-bit range.
//               When undefined, the result wraps by keeping bits [N-1:0].
//
// Ports:
//   clk                  system clock; all state changes on the rising edge
//   rst_n                asynchronous active-low reset
//   start                new sample present on fk; only looked at in IDLE
//   fk, fk_1, fk_2       delay-line taps x[k], x[k-1], x[k-2].
//                        These are 2N wide, and only bits [N-1:0] are used.
//   coef_b0..coef_b2     feed-forward coefficients, signed Q.FRAC
//   coef_a1, coef_a2     feedback coefficients, signed Q.FRAC
//   busy                 high while the sequencer is in M0..OUT
//   shift                one-cycle delay-line advance pulse, issued by OUT
//   y                    registered filter output, held until the next OUT
//   y_valid              one-cycle pulse, coincident with the y update

module iir_biquad_seq #(
    parameter int N    = 25,
    parameter int FRAC = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] fk,
    input  logic [2*N-1:0] fk_1,
    input  logic [2*N-1:0] fk_2,
    input  logic [N-1:0]   coef_b0,
    input  logic [N-1:0]   coef_b1,
    input  logic [N-1:0]   coef_b2,
    input  logic [N-1:0]   coef_a1,
    input  logic [N-1:0]   coef_a2,
    output logic           busy,
    output logic           shift,
    output logic [N-1:0]   y,
    output logic           y_valid
);

    localparam int PROD_W = 2 * N;
    // Three guard bits cover the sum of five full-scale products.
    localparam int ACC_W  = 2 * N + 3;

    typedef enum logic [2:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        M4,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc_shifted;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] op_coef_ext;
    logic signed [PROD_W-1:0] op_data_ext;
    logic        [N-1:0]      op_coef;
    logic        [N-1:0]      op_data;
    logic                     op_subtract;
    logic signed [N-1:0]      y1;
    logic signed [N-1:0]      y2;
    logic        [N-1:0]      result;

    // The upper halves of the taps carry only the sign extension.
    // This design never needs them.
    logic unused_tap_bits;
    assign unused_tap_bits = ^{fk[2*N-1:N], fk_1[2*N-1:N], fk_2[2*N-1:N]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a fixed walk through the five MAC steps.
    // A start that arrives outside IDLE is simply ignored.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? M0 : IDLE;
            M0:      state_next = M1;
            M1:      state_next = M2;
            M2:      state_next = M3;
            M3:      state_next = M4;
            M4:      state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Operand selection for the shared multiplier.
    // The feedback terms are subtracted, which saves a negation of a1 and a2.
    always_comb begin
        op_coef     = '0;
        op_data     = '0;
        op_subtract = 1'b0;
        case (state)
            M0: begin
                op_coef = coef_b0;
                op_data = fk[N-1:0];
            end
            M1: begin
                op_coef = coef_b1;
                op_data = fk_1[N-1:0];
            end
            M2: begin
                op_coef = coef_b2;
                op_data = fk_2[N-1:0];
            end
            M3: begin
                op_coef     = coef_a1;
                op_data     = y1;
                op_subtract = 1'b1;
            end
            M4: begin
                op_coef     = coef_a2;
                op_data     = y2;
                op_subtract = 1'b1;
            end
            default: begin
                op_coef     = '0;
                op_data     = '0;
                op_subtract = 1'b0;
            end
        endcase
    end

    // Multiply-accumulate path.
    // Both operands are sign-extended to the full product width first,
    // so the multiply is exact in two's complement.
    always_comb begin
        op_coef_ext = {{N{op_coef[N-1]}}, op_coef};
        op_data_ext = {{N{op_data[N-1]}}, op_data};
        product     = op_coef_ext * op_data_ext;
        prod_ext    = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};
        acc_next    = op_subtract ? (acc - prod_ext) : (acc + prod_ext);
        acc_shifted = acc >>> FRAC;
    end

`ifdef IIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - N + 1){1'b1}}, {(N - 1){1'b0}}};

    // Clamp the scaled sum into the signed N-bit output range.
    always_comb begin
        if (acc_shifted > SAT_MAX) begin
            result = SAT_MAX[N-1:0];
        end else if (acc_shifted < SAT_MIN) begin
            result = SAT_MIN[N-1:0];
        end else begin
            result = acc_shifted[N-1:0];
        end
    end
`else
    // Wrap: keep the low N bits and discard the rest.
    logic unused_acc_bits;
    assign unused_acc_bits = ^acc_shifted[ACC_W-1:N];

    always_comb begin
        result = acc_shifted[N-1:0];
    end
`endif

    // Datapath registers.
    // shift and y_valid are registered on the OUT cycle, so both pulses line
    // up with the new value of y. The next start can be accepted in that same
    // cycle. An asynchronous reset drops any sequence in progress without
    // issuing either pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            y       <= '0;
            y1      <= '0;
            y2      <= '0;
            y_valid <= 1'b0;
            shift   <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            shift   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                    end
                end
                M0, M1, M2, M3, M4: begin
                    acc <= acc_next;
                end
                OUT: begin
                    y       <= result;
                    y1      <= result;
                    y2      <= y1;
                    y_valid <= 1'b1;
                    shift   <= 1'b1;
                end
                default: begin
                    acc <= acc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// tb_iir_biquad_seq
// -----------------
// Purpose:
//   Self-checking bench for iir_biquad_seq. It has two parts:
//     - A table of directed vectors with hand-computed outputs. They run back
//       to back, so the y1/y2 history carries from one vector to the next.
//     - Hand-written sequences for the corner cases: feedback, a start
//       re-pulsed during M2, and a reset during M3.
//   Expected outputs for the overflow vectors depend on IIR_SAT_EN.
//
// Ports: none (top-level bench).

module tb_iir_biquad_seq;

    localparam int N    = 25;
    localparam int FRAC = 12;

    typedef struct {
        int b0;
        int b1;
        int b2;
        int a1;
        int a2;
        int x0;
        int x1;
        int x2;
        int exp_y;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] fk;
    logic [2*N-1:0] fk_1;
    logic [2*N-1:0] fk_2;
    logic [N-1:0]   coef_b0;
    logic [N-1:0]   coef_b1;
    logic [N-1:0]   coef_b2;
    logic [N-1:0]   coef_a1;
    logic [N-1:0]   coef_a2;
    logic           busy;
    logic           shift;
    logic [N-1:0]   y;
    logic           y_valid;

    int checks;
    int failures;
    int valid_count;
    int shift_count;

    iir_biquad_seq #(
        .N    (N),
        .FRAC (FRAC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .fk      (fk),
        .fk_1    (fk_1),
        .fk_2    (fk_2),
        .coef_b0 (coef_b0),
        .coef_b1 (coef_b1),
        .coef_b2 (coef_b2),
        .coef_a1 (coef_a1),
        .coef_a2 (coef_a2),
        .busy    (busy),
        .shift   (shift),
        .y       (y),
        .y_valid (y_valid)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Each pulse lasts one cycle, so each one is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (y_valid) valid_count++;
        if (shift)   shift_count++;
    end

    // Watchdog: stops the run if the bench ever hangs.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison: counts it, and reports it only if it is wrong.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [2*N-1:0] sext_tap(input int v);
        logic [N-1:0] low;
        low = N'(v);
        return {{N{low[N-1]}}, low};
    endfunction

    task automatic driveVector(input vec_t v);
        coef_b0 = N'(v.b0);
        coef_b1 = N'(v.b1);
        coef_b2 = N'(v.b2);
        coef_a1 = N'(v.a1);
        coef_a2 = N'(v.a2);
        fk      = sext_tap(v.x0);
        fk_1    = sext_tap(v.x1);
        fk_2    = sext_tap(v.x2);
    endtask

    // Runs one sample through the filter and checks latency, busy, y and the pulses.
    task automatic applyStimulus(input vec_t v, input string tag);
        int waited;
        int busy_cycles;
        @(negedge clk);
        driveVector(v);
        start = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        waited      = 0;
        busy_cycles = 0;
        while (!y_valid && waited < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_latency"}, waited, 6);
        checkOutput({tag, "_busy_cycles"}, busy_cycles, 6);
        checkOutput({tag, "_y"}, int'($signed(y)), v.exp_y);
        checkOutput({tag, "_shift_with_valid"}, int'(shift), 1);
        checkOutput({tag, "_busy_idle"}, int'(busy), 0);
        @(negedge clk);
        checkOutput({tag, "_valid_end"}, int'(y_valid), 0);
        checkOutput({tag, "_shift_end"}, int'(shift), 0);
        checkOutput({tag, "_y_hold"}, int'($signed(y)), v.exp_y);
    endtask

    task automatic resetDut(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_rst_y"}, int'($signed(y)), 0);
        checkOutput({tag, "_rst_busy"}, int'(busy), 0);
        checkOutput({tag, "_rst_valid"}, int'(y_valid), 0);
        checkOutput({tag, "_rst_shift"}, int'(shift), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vecs[10];
        vec_t v;
        int vc0;
        int sc0;
        int ovf_pos;
        int ovf_neg;

`ifdef IIR_SAT_EN
        ovf_pos = 16777215;
        ovf_neg = -16777216;
`else
        ovf_pos = 0;
        ovf_neg = 0;
`endif

        // Columns: b0, b1, b2, a1, a2, x0, x1, x2, expected y.
        // The y1/y2 history carries from row to row.
        vecs[0] = '{4096,     0,    0,     0,     0,   1000,    0,   0, 1000};
        vecs[1] = '{   0,  4096,    0,     0,     0,      5,   -7,   9,   -7};
        vecs[2] = '{   0,     0, 4096,     0,     0,     11,   22, 123,  123};
        vecs[3] = '{2048,     0,    0,     0,     0,     -3,    0,   0,   -2};
        vecs[4] = '{   0,     0,    0,     0, -4096,      0,    0,   0,  123};
        vecs[5] = '{   0,     0,    0,  4096,     0,      0,    0,   0, -123};
        vecs[6] = '{4096,  4096, 4096,     0,     0,    100,  200, 300,  600};
        vecs[7] = '{1024,     0,    0, -4096,  4096,    400,    0,   0,  823};
        vecs[8] = '{16384,    0,    0,     0,     0,  8388608,  0,   0, ovf_pos};
        vecs[9] = '{16384,    0,    0,     0,     0, -8388608,  0,   0, ovf_neg};

        checks      = 0;
        failures    = 0;
        valid_count = 0;
        shift_count = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        v           = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        driveVector(v);

        resetDut("init");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Feedback: y = x + 0.5*y1, with an impulse of 1.0 at the input.
        resetDut("fb");
        v = '{4096, 0, 0, -2048, 0, 4096, 0, 0, 4096};
        applyStimulus(v, "fb0");
        v = '{4096, 0, 0, -2048, 0, 0, 0, 0, 2048};
        applyStimulus(v, "fb1");
        v = '{4096, 0, 0, -2048, 0, 0, 0, 0, 1024};
        applyStimulus(v, "fb2");

        // A start re-pulsed while in M2 must not queue a second sequence.
        resetDut("rep");
        v = '{4096, 0, 0, 0, 0, 1000, 0, 0, 1000};
        vc0 = valid_count;
        sc0 = shift_count;
        @(negedge clk);
        driveVector(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("rep_valid_pulses", valid_count - vc0, 1);
        checkOutput("rep_shift_pulses", shift_count - sc0, 1);
        checkOutput("rep_y", int'($signed(y)), 1000);
        checkOutput("rep_busy_idle", int'(busy), 0);

        // Reset during M3: the outputs clear at once, and no pulses are issued.
        vc0 = valid_count;
        sc0 = shift_count;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("m3_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("m3_rst_y", int'($signed(y)), 0);
        checkOutput("m3_rst_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("m3_no_valid", valid_count - vc0, 0);
        checkOutput("m3_no_shift", shift_count - sc0, 0);
        // With only feedback coefficients, y = y1 + y2, which must read zero.
        v = '{0, 0, 0, -4096, -4096, 0, 0, 0, 0};
        applyStimulus(v, "m3_hist");
        v = '{4096, 0, 0, 0, 0, 1000, 0, 0, 1000};
        applyStimulus(v, "m3_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iir_biquad_seq.md
Name: iir_biquad_seq

Overview:
Consumer and sequencer for the three-tap sample delay line (fk, fk_1, fk_2 plus its shift strobe) used in the filter datapath. On each new sample it runs a direct-form-I second-order IIR section over five cycles using one multiplier and one accumulator. It keeps its own output history (y1, y2), produces a saturated N-bit result, and issues the single-cycle shift pulse that advances the delay line.

Parameters:
N, 25, sample/coefficient width in bits (signed two's complement)
FRAC, 12, fractional bits of the coefficients (coef 4096 = 1.0 at default)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  new sample present on fk; sampled only in IDLE
fk  in  2N  current sample tap x[k]; bits [N-1:0] used, upper N ignored (delay line In driven by sign-extended sample)
fk_1  in  2N  tap x[k-1]; bits [N-1:0] used
fk_2  in  2N  tap x[k-2]; bits [N-1:0] used
coef_b0, coef_b1, coef_b2  in  N each  feed-forward coefficients, signed Q.FRAC
coef_a1, coef_a2  in  N each  feedback coefficients, signed Q.FRAC
busy  out  1  high from the cycle after start is accepted until return to IDLE
shift  out  1  one-cycle pulse to the delay line, asserted in the OUT state
y  out  N  registered filter output, holds until the next OUT
y_valid  out  1  one-cycle pulse, coincident with y update

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, y=0, y1=0, y2=0, busy=0, shift=0, y_valid=0. Reset mid-sequence aborts; no shift or y_valid is issued.
- Equation: y[k] = (b0*x[k] + b1*x[k-1] + b2*x[k-2] - a1*y1 - a2*y2) >>> FRAC.
- States: IDLE -> M0 -> M1 -> M2 -> M3 -> M4 -> OUT -> IDLE.
- IDLE: if start=1, go to M0 and clear acc. start while not in IDLE is ignored (no queueing).
- M0..M4: one signed N x N product (2N bits) per state, sign-extended into acc (2N+3 bits). Order: b0*fk, +b1*fk_1, +b2*fk_2, -a1*y1, -a2*y2. Taps are read combinationally in their own state and must stay stable from start through M2.
- OUT: result = acc >>> FRAC (arithmetic, floor rounding), reduced to N bits per the optional feature. In this state: y<=result, y2<=y1, y1<=result, y_valid=1, shift=1 for exactly one cycle. Then go to IDLE.
- Latency: start sampled at edge 0; y and y_valid visible after edge 6. A new start is accepted on the cycle after OUT, giving a throughput of 1 sample per 7 cycles.
- busy=1 in M0..OUT, 0 in IDLE.
- Coefficients are sampled live each cycle and must be held stable during a sequence.

Optional Feature:
IIR_SAT_EN
- Defined: result is clamped to [-2^(N-1), 2^(N-1)-1] before being written to y and y1.
- Undefined: result is truncated to bits [N-1:0] (two's-complement wrap), with no extra logic.

Test Plan:
- Reset then b0=4096, others 0, fk=1000, pulse start -> busy high 6 cycles; after edge 6, y=1000, y_valid=1 and shift=1 for exactly one cycle.
- b1=4096, others 0, fk_1=-7 -> y=-7 (product -28672 >>> 12); fk and fk_2 values have no effect.
- Feedback: b0=4096, a1=-2048. Three starts with fk=4096, 0, 0 -> y=4096, 2048, 1024; y1/y2 history is correct across sequences.
- Overflow: b0=16384, fk=2^23. With IIR_SAT_EN -> y=16777215. Without -> y=0 (wrap).
- start re-pulsed during M2 -> ignored: exactly one y_valid and one shift per accepted start.
- rst_n dropped during M3 -> outputs and history go to 0 immediately, no shift/y_valid. After release, the next start behaves as in the first test.
